// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and occupancy encoding for fifo_buffer and the UART top level.
package fifo_pkg;

    localparam int FIFO_DEF_NB_DATA = 8;
    localparam int FIFO_DEF_NB_ADDR = 4;
    localparam int FIFO_DEF_DEPTH   = 2 ** FIFO_DEF_NB_ADDR;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    function automatic occ_state_e occ_decode(input logic is_empty, input logic is_full);
        occ_state_e occ;
        occ = OCC_PARTIAL;
        if (is_empty) begin
            occ = OCC_EMPTY;
        end else if (is_full) begin
            occ = OCC_FULL;
        end
        return occ;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register file: synchronous write port, combinational read port.
module fifo_ram #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);

    localparam int DEPTH = 2 ** NB_ADDR;

    // Contents are deliberately left unreset; stale words are masked by the pointers.
    logic [NB_DATA-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fifo_buffer.sv
// First-word-fall-through FIFO between the UART receiver and the interface FSM.
// Optional sticky OVERFLOW/UNDERFLOW flags with CLRERR are enabled by defining FIFO_ERRFLAGS_EN.
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int NB_FIFO_DATA = fifo_pkg::FIFO_DEF_NB_DATA,
    parameter int NB_FIFO_ADDR = fifo_pkg::FIFO_DEF_NB_ADDR
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_fifo_WRITE,
    input  logic [NB_FIFO_DATA-1:0] i_fifo_WRITEDATA,
    input  logic                    i_fifo_READ,
`ifdef FIFO_ERRFLAGS_EN
    input  logic                    i_fifo_CLRERR,
    output logic                    o_fifo_OVERFLOW,
    output logic                    o_fifo_UNDERFLOW,
`endif
    output logic [NB_FIFO_DATA-1:0] o_fifo_READDATA,
    output logic                    o_fifo_EMPTY,
    output logic                    o_fifo_FULL
);

    localparam logic [NB_FIFO_ADDR:0] PTR_ONE = 1;

    logic [NB_FIFO_ADDR:0]   wr_ptr_q, wr_ptr_d;
    logic [NB_FIFO_ADDR:0]   rd_ptr_q, rd_ptr_d;
    logic [NB_FIFO_DATA-1:0] ram_rdata;
    occ_state_e              occ;
    logic                    ptr_empty;
    logic                    ptr_full;
    logic                    push_acc;
    logic                    pop_acc;
    logic                    push_drop;
    logic                    pop_ignored;

    // Extra pointer MSB separates a wrapped (full) pointer pair from an equal (empty) one.
    assign ptr_empty = (wr_ptr_q == rd_ptr_q);
    assign ptr_full  = (wr_ptr_q[NB_FIFO_ADDR-1:0] == rd_ptr_q[NB_FIFO_ADDR-1:0])
                    && (wr_ptr_q[NB_FIFO_ADDR] != rd_ptr_q[NB_FIFO_ADDR]);
    assign occ       = occ_decode(ptr_empty, ptr_full);

    assign o_fifo_EMPTY = (occ == OCC_EMPTY);
    assign o_fifo_FULL  = (occ == OCC_FULL);

    // A pop frees the slot in the same edge, so a full FIFO still takes a paired push.
    assign pop_acc     = i_fifo_READ && !o_fifo_EMPTY;
    assign push_acc    = i_fifo_WRITE && (!o_fifo_FULL || pop_acc);
    assign push_drop   = i_fifo_WRITE && !push_acc;
    assign pop_ignored = i_fifo_READ && o_fifo_EMPTY;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_ram #(
        .NB_DATA (NB_FIFO_DATA),
        .NB_ADDR (NB_FIFO_ADDR)
    ) u_fifo_ram (
        .i_clk   (i_clk),
        .i_we    (push_acc),
        .i_waddr (wr_ptr_q[NB_FIFO_ADDR-1:0]),
        .i_wdata (i_fifo_WRITEDATA),
        .i_raddr (rd_ptr_q[NB_FIFO_ADDR-1:0]),
        .o_rdata (ram_rdata)
    );

    assign o_fifo_READDATA = o_fifo_EMPTY ? '0 : ram_rdata;

`ifdef FIFO_ERRFLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error event takes priority over a clear issued in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_fifo_CLRERR) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push_drop) begin
            overflow_d = 1'b1;
        end
        if (pop_ignored) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_fifo_OVERFLOW  = overflow_q;
    assign o_fifo_UNDERFLOW = underflow_q;
`else
    logic unused_flags;
    assign unused_flags = push_drop ^ pop_ignored;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Scoreboard bench for fifo_buffer: stimulus queues expected words, a negedge monitor checks pops.
module tb_fifo_buffer;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    logic [7:0] rdata;
    logic       empty;
    logic       full;
`ifdef FIFO_ERRFLAGS_EN
    logic       clrerr;
    logic       ovf;
    logic       unf;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    fifo_buffer #(
        .NB_FIFO_DATA (8),
        .NB_FIFO_ADDR (4)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_fifo_WRITE     (wr),
        .i_fifo_WRITEDATA (wdata),
        .i_fifo_READ      (rd),
`ifdef FIFO_ERRFLAGS_EN
        .i_fifo_CLRERR    (clrerr),
        .o_fifo_OVERFLOW  (ovf),
        .o_fifo_UNDERFLOW (unf),
`endif
        .o_fifo_READDATA  (rdata),
        .o_fifo_EMPTY     (empty),
        .o_fifo_FULL      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%02h", name, act);
        end
    endtask

    // Monitor: whenever the DUT is about to complete a pop, the head must match the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rd && !empty) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", rdata, 8'hxx);
            end else begin
                chk("pop_data", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1; wdata = d; rd = 1'b0;
        exp_q.push_back(d);
        tick();
        wr = 1'b0;
    endtask

    task automatic push_dropped(input logic [7:0] d);
        wr = 1'b1; wdata = d; rd = 1'b0;
        tick();
        wr = 1'b0;
    endtask

    task automatic pop();
        wr = 1'b0; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] d);
        wr = 1'b1; wdata = d; rd = 1'b1;
        exp_q.push_back(d);
        tick();
        wr = 1'b0; rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; wdata = 8'h00; rd = 1'b0;
`ifdef FIFO_ERRFLAGS_EN
        clrerr = 1'b0;
`endif
        #3;
        chk("reset_empty", {7'd0, empty}, 8'd1);
        chk("reset_full", {7'd0, full}, 8'd0);
        chk("reset_rdata", rdata, 8'h00);
        tick(); tick();
        rst_n = 1'b1;

        // Single word: first push accepted on the first edge after release.
        push(8'h2B);
        chk("one_empty", {7'd0, empty}, 8'd0);
        chk("one_rdata", rdata, 8'h2B);
        pop();
        chk("one_pop_empty", {7'd0, empty}, 8'd1);
        chk("one_pop_rdata", rdata, 8'h00);

        // Fill to 16, overflow, drain in order.
        for (int i = 0; i < 15; i++) push(8'(i));
        chk("fill15_full", {7'd0, full}, 8'd0);
        push(8'h0F);
        chk("fill16_full", {7'd0, full}, 8'd1);
        push_dropped(8'hAA);
        chk("drop_full", {7'd0, full}, 8'd1);
        chk("drop_head", rdata, 8'h00);
`ifdef FIFO_ERRFLAGS_EN
        chk("overflow_set", {7'd0, ovf}, 8'd1);
        clrerr = 1'b1; wr = 1'b1; wdata = 8'hAB;
        tick();
        chk("overflow_set_beats_clr", {7'd0, ovf}, 8'd1);
        wr = 1'b0;
        tick();
        clrerr = 1'b0;
        chk("overflow_cleared", {7'd0, ovf}, 8'd0);
`endif
        for (int i = 0; i < 16; i++) pop();
        chk("drain_empty", {7'd0, empty}, 8'd1);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        push_pop(8'h55);
        chk("fullrw_full", {7'd0, full}, 8'd1);
        chk("fullrw_head", rdata, 8'h11);
        for (int i = 0; i < 15; i++) pop();
        chk("fullrw_last", rdata, 8'h55);
        pop();
        chk("fullrw_empty", {7'd0, empty}, 8'd1);

        // READ on empty ignored; simultaneous push still stored.
        push_pop(8'h77);
        chk("emptyrw_empty", {7'd0, empty}, 8'd0);
        chk("emptyrw_rdata", rdata, 8'h77);
`ifdef FIFO_ERRFLAGS_EN
        chk("underflow_set", {7'd0, unf}, 8'd1);
`endif
        pop();

        // Pointer wrap: one word resident, 40 push/pop pairs.
        push(8'h80);
        for (int i = 1; i <= 40; i++) begin
            push_pop(8'h80 + 8'(i));
            if (empty || full) chk("wrap_flags", {6'd0, empty, full}, 8'd0);
        end
        chk("wrap_head", rdata, 8'hA8);
        pop();
        chk("wrap_empty", {7'd0, empty}, 8'd1);

        // Asynchronous reset between edges while 5 words are held.
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        chk("hold5_head", rdata, 8'hA0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_empty", {7'd0, empty}, 8'd1);
        chk("async_full", {7'd0, full}, 8'd0);
        chk("async_rdata", rdata, 8'h00);
`ifdef FIFO_ERRFLAGS_EN
        chk("async_unf_clr", {7'd0, unf}, 8'd0);
`endif
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        push(8'hC3);
        chk("post_reset_rdata", rdata, 8'hC3);
        pop();
        chk("post_reset_empty", {7'd0, empty}, 8'd1);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d words expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
